// File: rtl/time_pkg.sv
// Shared time-keeping types and constants for the BCD field counters.
package time_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t ones;
  } bcd2_t;

  localparam int unsigned SEC_MOD       = 60;
  localparam int unsigned MIN_MOD       = 60;
  localparam int unsigned HOUR_MOD      = 24;
  localparam int unsigned BCD_MAX_DIGIT = 9;

  // Binary 0..99 to packed two-digit BCD.
  function automatic bcd2_t to_bcd2(input int unsigned v);
    bcd2_t r;
    r.tens = 4'(v / 10);
    r.ones = 4'(v % 10);
    return r;
  endfunction

endpackage

// File: rtl/bcd_mod_counter_if.sv
// Enable and count bundle between the clock block (master) and one field counter (slave).
interface bcd_mod_counter_if;
  import time_pkg::*;

  logic       EN;
  logic [7:0] Cnt;
  bcd_digit_t CntH;
  bcd_digit_t CntL;
  logic       tc;

  modport master (output EN, input Cnt, input CntH, input CntL, input tc);
  modport slave  (input EN, output Cnt, output CntH, output CntL, output tc);
endinterface

// File: rtl/bcd_mod_counter_digit.sv
// Single decade counter; clr overrides inc, carry flags a 9 -> 0 rollover.
module bcd_digit
  import time_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output bcd_digit_t digit,
  output logic       carry
);

  bcd_digit_t digit_q, digit_d;
  logic       at_nine;

  assign at_nine = (digit_q == 4'(BCD_MAX_DIGIT));

  always_comb begin
    digit_d = digit_q;
    if (clr)
      digit_d = '0;
    else if (inc)
      digit_d = at_nine ? '0 : digit_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      digit_q <= '0;
    else
      digit_q <= digit_d;
  end

  assign digit = digit_q;
  assign carry = at_nine & inc;

endmodule

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter for one time field (60 for sec/min, 24 for hours).
module bcd_mod_counter
  import time_pkg::*;
#(
  parameter int unsigned MODULUS = 60
) (
  input logic             CP,
  input logic             reset,
  bcd_mod_counter_if.slave bus
);

  localparam bcd2_t CNT_MAX = to_bcd2(MODULUS - 1);

  bcd2_t      cnt;
  logic       ones_carry;
  logic       at_max;
  logic       illegal;
  logic       clr;
  logic [7:0] cnt_bin;

  assign cnt_bin = {4'd0, cnt.tens} * 8'd10 + {4'd0, cnt.ones};
  assign at_max  = (cnt == CNT_MAX);

  // Non-BCD or out-of-range state clears on the next edge even with EN low.
  assign illegal = (cnt.ones > 4'(BCD_MAX_DIGIT)) |
                   (cnt.tens > 4'(BCD_MAX_DIGIT)) |
                   (cnt_bin >= 8'(MODULUS));
  assign clr     = illegal | (at_max & bus.EN);

  bcd_digit u_ones (
    .clk   (CP),
    .reset (reset),
    .inc   (bus.EN),
    .clr   (clr),
    .digit (cnt.ones),
    .carry (ones_carry)
  );

  bcd_digit u_tens (
    .clk   (CP),
    .reset (reset),
    .inc   (ones_carry),
    .clr   (clr),
    .digit (cnt.tens),
    .carry ()
  );

  assign bus.Cnt  = cnt;
  assign bus.CntH = cnt.tens;
  assign bus.CntL = cnt.ones;
  assign bus.tc   = bus.EN & at_max;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench for the 60 and 24 configurations of the BCD field counter.
module tb_bcd_mod_counter;

  logic clk = 1'b0;
  logic rst60, rst24;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  bcd_mod_counter_if bus60 ();
  bcd_mod_counter_if bus24 ();

  bcd_mod_counter #(.MODULUS(60)) dut60 (.CP(clk), .reset(rst60), .bus(bus60.slave));
  bcd_mod_counter #(.MODULUS(24)) dut24 (.CP(clk), .reset(rst24), .bus(bus24.slave));

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] exp_cnt;
    logic       exp_tc;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] dec2bcd(input int unsigned v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic chk60(input string name, input int unsigned m, input logic exp_tc);
    chk({name, "_cnt"}, bus60.Cnt, dec2bcd(m));
    chk({name, "_H"}, {4'd0, bus60.CntH}, {4'd0, 4'(m / 10)});
    chk({name, "_L"}, {4'd0, bus60.CntL}, {4'd0, 4'(m % 10)});
    chk({name, "_tc"}, {7'd0, bus60.tc}, {7'd0, exp_tc});
  endtask

  task automatic chk24(input string name, input int unsigned m, input logic exp_tc);
    chk({name, "_cnt"}, bus24.Cnt, dec2bcd(m));
    chk({name, "_H"}, {4'd0, bus24.CntH}, {4'd0, 4'(m / 10)});
    chk({name, "_L"}, {4'd0, bus24.CntL}, {4'd0, 4'(m % 10)});
    chk({name, "_tc"}, {7'd0, bus24.tc}, {7'd0, exp_tc});
  endtask

  initial begin
    vecs[0] = '{rst: 1'b1, en: 1'b1, exp_cnt: 8'h00, exp_tc: 1'b0};
    vecs[1] = '{rst: 1'b1, en: 1'b1, exp_cnt: 8'h00, exp_tc: 1'b0};
    vecs[2] = '{rst: 1'b0, en: 1'b1, exp_cnt: 8'h01, exp_tc: 1'b0};
    vecs[3] = '{rst: 1'b0, en: 1'b0, exp_cnt: 8'h01, exp_tc: 1'b0};
    vecs[4] = '{rst: 1'b0, en: 1'b1, exp_cnt: 8'h02, exp_tc: 1'b0};
    vecs[5] = '{rst: 1'b0, en: 1'b0, exp_cnt: 8'h02, exp_tc: 1'b0};

    rst60 = 1'b1; bus60.EN = 1'b1;
    rst24 = 1'b1; bus24.EN = 1'b1;
    #1;

    // Table: reset with EN high, then basic enable/hold.
    for (int i = 0; i < 6; i++) begin
      rst60    = vecs[i].rst;
      bus60.EN = vecs[i].en;
      tick();
      chk($sformatf("vec%0d_cnt", i), bus60.Cnt, vecs[i].exp_cnt);
      chk($sformatf("vec%0d_tc", i), {7'd0, bus60.tc}, {7'd0, vecs[i].exp_tc});
    end
    chk60("reset_fields", 2, 1'b0);

    // Full mod-60 sweep from 00.
    rst60 = 1'b1; tick();
    rst60 = 1'b0; bus60.EN = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      int unsigned m;
      m = i % 60;
      tick();
      chk60($sformatf("m60_%0d", i), m, m == 59);
      chk($sformatf("m60_ones_ok_%0d", i), {7'd0, bus60.CntL <= 4'd9}, 8'd1);
    end

    // Enable gating at 14.
    rst60 = 1'b1; tick();
    rst60 = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk60("gate_14", 14, 1'b0);
    bus60.EN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk60($sformatf("gate_hold%0d", i), 14, 1'b0);
    end
    bus60.EN = 1'b1; tick();
    chk60("gate_15", 15, 1'b0);

    // Reset beats EN at 58.
    for (int i = 0; i < 43; i++) tick();
    chk60("pri_58", 58, 1'b0);
    rst60 = 1'b1; tick();
    chk60("pri_rst", 0, 1'b0);
    rst60 = 1'b0; tick();
    chk60("pri_01", 1, 1'b0);

    // tc follows EN combinationally at 59 and is not gated by reset.
    for (int i = 0; i < 58; i++) tick();
    bus60.EN = 1'b0; #1;
    chk60("tc_en0_59", 59, 1'b0);
    bus60.EN = 1'b1; rst60 = 1'b1; #1;
    chk60("tc_rst_59", 59, 1'b1);
    tick();
    chk60("tc_rst_after", 0, 1'b0);
    rst60 = 1'b0;

    // Illegal non-BCD state recovers with EN low.
    bus60.EN = 1'b0;
    force dut60.u_tens.digit_q = 4'h3;
    force dut60.u_ones.digit_q = 4'hC;
    #1;
    chk("ill60_forced", bus60.Cnt, 8'h3C);
    release dut60.u_tens.digit_q;
    release dut60.u_ones.digit_q;
    tick();
    chk60("ill60_recover", 0, 1'b0);

    // Mod-24: reset with EN high for two edges, then full sweep.
    rst24 = 1'b1; bus24.EN = 1'b1;
    tick(); tick();
    chk24("m24_reset", 0, 1'b0);
    rst24 = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      int unsigned m;
      m = i % 24;
      tick();
      chk24($sformatf("m24_%0d", i), m, m == 23);
    end

    // Out-of-range but valid BCD recovers with EN low.
    bus24.EN = 1'b0;
    force dut24.u_tens.digit_q = 4'h2;
    force dut24.u_ones.digit_q = 4'h5;
    #1;
    chk("ill24_forced", bus24.Cnt, 8'h25);
    release dut24.u_tens.digit_q;
    release dut24.u_ones.digit_q;
    tick();
    chk24("ill24_recover", 0, 1'b0);
    bus24.EN = 1'b1; tick();
    chk24("ill24_resume", 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
